// File: rtl/pbit_update_sequencer_pkg.sv
// Shared types, mode encodings and elaboration-time parameter helpers for the
// p-bit update sequencer.
package pbit_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_COLOR = 1'b1;

    // Counter must hold the largest of the two phase lengths.
    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int longest;
        longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

    function automatic bit params_ok(input int n_pbits, input int hold_cycles,
                                     input int gap_cycles);
        return (n_pbits >= 2) && (hold_cycles >= 1) && (gap_cycles >= 0);
    endfunction

endpackage

// File: rtl/pbit_update_sequencer_if.sv
// Control/status bundle between the system controller (master) and the
// update sequencer (slave).
interface pbit_update_sequencer_if #(
    parameter int N_PBITS = 3,
    parameter int IDX_W   = $clog2(N_PBITS)
);
    logic               EN;
    logic               MODE;
    logic [N_PBITS-1:0] SKIP_MASK;
    logic [N_PBITS-1:0] COLOR_MASK;
    logic [N_PBITS-1:0] UPDATE_SEQ;
    logic [IDX_W-1:0]   ACTIVE_IDX;
    logic               SWEEP_DONE;
    logic               BUSY;

    modport master (
        output EN, MODE, SKIP_MASK, COLOR_MASK,
        input  UPDATE_SEQ, ACTIVE_IDX, SWEEP_DONE, BUSY
    );

    modport slave (
        input  EN, MODE, SKIP_MASK, COLOR_MASK,
        output UPDATE_SEQ, ACTIVE_IDX, SWEEP_DONE, BUSY
    );
endinterface

// File: rtl/pbit_update_sequencer_next_slot.sv
// Combinational round-robin finder: lowest eligible index strictly above idx_i,
// wrapping to the lowest eligible index overall when none is above.
module pbit_next_slot #(
    parameter int N_PBITS = 3,
    parameter int IDX_W   = $clog2(N_PBITS)
) (
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [N_PBITS-1:0] mask_i,
    output logic [IDX_W-1:0]   next_idx_o,
    output logic               wrap_o,
    output logic               empty_o
);

    logic [IDX_W-1:0] above_idx_s;
    logic [IDX_W-1:0] low_idx_s;
    logic             above_found_s;

    // Downward scan: the last hit written is the lowest qualifying index.
    always_comb begin
        above_idx_s   = '0;
        low_idx_s     = '0;
        above_found_s = 1'b0;
        for (int i = N_PBITS - 1; i >= 0; i--) begin
            low_idx_s     = mask_i[i] ? IDX_W'(i) : low_idx_s;
            above_idx_s   = (mask_i[i] && (i > int'(idx_i))) ? IDX_W'(i) : above_idx_s;
            above_found_s = above_found_s | (mask_i[i] && (i > int'(idx_i)));
        end
    end

    assign next_idx_o = above_found_s ? above_idx_s : low_idx_s;
    assign wrap_o     = ~above_found_s;
    assign empty_o    = (mask_i == '0);

endmodule

// File: rtl/pbit_update_sequencer.sv
// Update-enable sequencer for a p-bit array: round-robin one-hot or two-colour
// group strobes, each held HOLD_CYCLES and followed by GAP_CYCLES of silence.
module pbit_update_sequencer
    import pbit_seq_pkg::*;
#(
    parameter int N_PBITS     = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1,
    parameter int IDX_W       = $clog2(N_PBITS)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    pbit_update_sequencer_if.slave   bus
);

    localparam int               CNT_W     = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PBITS - 1);
    localparam logic [N_PBITS-1:0] ONE_HOT0 = {{(N_PBITS-1){1'b0}}, 1'b1};

    if (!params_ok(N_PBITS, HOLD_CYCLES, GAP_CYCLES)) begin : g_param_check
        $error("pbit_update_sequencer: illegal parameter set");
    end

    seq_state_e         state_q, state_d, state_p;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_p;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mode_q, mode_d;
    logic [N_PBITS-1:0] skip_q, skip_d;
    logic [N_PBITS-1:0] color_q, color_d;
    logic [N_PBITS-1:0] upd_q, upd_d;
    logic               sweep_q, sweep_d;
    logic               busy_q, busy_d;

    logic               slot_end_s;
    logic               start_new_s;

    // Live configuration: used only when a fresh sweep is latched.
    logic [N_PBITS-1:0] live_a_s, live_b_s;
    logic [IDX_W-1:0]   live_rr_first_s, live_first_s;
    logic               live_rr_empty_s, live_empty_s;
    logic               live_wrap_unused;

    assign live_a_s = bus.COLOR_MASK & ~bus.SKIP_MASK;
    assign live_b_s = ~bus.COLOR_MASK & ~bus.SKIP_MASK;

    pbit_next_slot #(.N_PBITS(N_PBITS), .IDX_W(IDX_W)) u_first_slot (
        .idx_i      (LAST_IDX),
        .mask_i     (~bus.SKIP_MASK),
        .next_idx_o (live_rr_first_s),
        .wrap_o     (live_wrap_unused),
        .empty_o    (live_rr_empty_s)
    );

    assign live_first_s = (bus.MODE == MODE_RR) ? live_rr_first_s
                        : ((live_a_s != '0) ? '0 : IDX_W'(1));
    assign live_empty_s = (bus.MODE == MODE_RR) ? live_rr_empty_s
                        : ((live_a_s == '0) && (live_b_s == '0));

    // Successor of the current slot within the latched list.
    logic [N_PBITS-1:0] lat_b_s;
    logic [IDX_W-1:0]   cur_rr_next_s, cur_next_s;
    logic               cur_wrap_s, cur_empty_s, cur_last_s;

    assign lat_b_s = ~color_q & ~skip_q;

    pbit_next_slot #(.N_PBITS(N_PBITS), .IDX_W(IDX_W)) u_cur_slot (
        .idx_i      (idx_q),
        .mask_i     (~skip_q),
        .next_idx_o (cur_rr_next_s),
        .wrap_o     (cur_wrap_s),
        .empty_o    (cur_empty_s)
    );

    assign cur_next_s = (mode_q == MODE_RR) ? cur_rr_next_s : IDX_W'(1);
    assign cur_last_s = (mode_q == MODE_RR) ? (cur_wrap_s || cur_empty_s)
                      : ((idx_q != '0) || (lat_b_s == '0));

    // Phase progression inside a slot, ignoring what follows the slot.
    always_comb begin
        state_p    = state_q;
        cnt_p      = cnt_q;
        slot_end_s = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    if (HAS_GAP) begin
                        state_p = ST_GAP;
                        cnt_p   = '0;
                    end else begin
                        slot_end_s = 1'b1;
                    end
                end else begin
                    cnt_p = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    slot_end_s = 1'b1;
                end else begin
                    cnt_p = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_p = ST_IDLE;
                cnt_p   = '0;
            end
        endcase
    end

    assign start_new_s = bus.EN && ((state_q == ST_IDLE) || (slot_end_s && cur_last_s));

    // Slot sequencing: latch a new list, advance within it, or return to idle.
    always_comb begin
        state_d = state_p;
        cnt_d   = cnt_p;
        idx_d   = idx_q;
        mode_d  = mode_q;
        skip_d  = skip_q;
        color_d = color_q;
        if (start_new_s) begin
            mode_d  = bus.MODE;
            skip_d  = bus.SKIP_MASK;
            color_d = bus.COLOR_MASK;
            cnt_d   = '0;
            if (live_empty_s) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                state_d = ST_HOLD;
                idx_d   = live_first_s;
            end
        end else if (slot_end_s) begin
            cnt_d = '0;
            if (!bus.EN) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                state_d = ST_HOLD;
                idx_d   = cur_next_s;
            end
        end else begin
            state_d = state_p;
            cnt_d   = cnt_p;
        end
    end

    // Whether the slot occupied next cycle is the last of its sweep.
    logic [N_PBITS-1:0] new_a_s, new_b_s;
    logic [IDX_W-1:0]   new_next_unused;
    logic               new_wrap_s, new_empty_s, new_last_s;

    assign new_a_s = color_d & ~skip_d;
    assign new_b_s = ~color_d & ~skip_d;

    pbit_next_slot #(.N_PBITS(N_PBITS), .IDX_W(IDX_W)) u_new_slot (
        .idx_i      (idx_d),
        .mask_i     (~skip_d),
        .next_idx_o (new_next_unused),
        .wrap_o     (new_wrap_s),
        .empty_o    (new_empty_s)
    );

    assign new_last_s = (mode_d == MODE_RR) ? (new_wrap_s || new_empty_s)
                      : ((idx_d != '0) || (new_b_s == '0));

    // Strobe pattern for the upcoming cycle.
    always_comb begin
        upd_d = '0;
        if (state_d == ST_HOLD) begin
            if (mode_d == MODE_RR) begin
                upd_d = ONE_HOT0 << idx_d;
            end else if (idx_d == '0) begin
                upd_d = new_a_s;
            end else begin
                upd_d = new_b_s;
            end
        end else begin
            upd_d = '0;
        end
    end

    assign sweep_d = new_last_s &&
                     (((state_d == ST_GAP) && (cnt_d == GAP_LAST)) ||
                      ((state_d == ST_HOLD) && !HAS_GAP && (cnt_d == HOLD_LAST)));
    assign busy_d  = (state_d != ST_IDLE);

    // State, latched configuration and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mode_q  <= MODE_RR;
            skip_q  <= '0;
            color_q <= '0;
            upd_q   <= '0;
            sweep_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            skip_q  <= skip_d;
            color_q <= color_d;
            upd_q   <= upd_d;
            sweep_q <= sweep_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.UPDATE_SEQ = upd_q;
    assign bus.ACTIVE_IDX = idx_q;
    assign bus.SWEEP_DONE = sweep_q;
    assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_pbit_update_sequencer.sv
// Directed bench: three sequencer configurations driven from hand-written
// expected strobe tables.
module tb_pbit_update_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pbit_update_sequencer_if #(.N_PBITS(3)) if_a ();
    pbit_update_sequencer_if #(.N_PBITS(5)) if_b ();
    pbit_update_sequencer_if #(.N_PBITS(4)) if_c ();

    pbit_update_sequencer #(.N_PBITS(3), .HOLD_CYCLES(2), .GAP_CYCLES(1)) dut_a (
        .CLK(clk), .RST_N(rst_n), .bus(if_a));
    pbit_update_sequencer #(.N_PBITS(5), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .CLK(clk), .RST_N(rst_n), .bus(if_b));
    pbit_update_sequencer #(.N_PBITS(4), .HOLD_CYCLES(2), .GAP_CYCLES(1)) dut_c (
        .CLK(clk), .RST_N(rst_n), .bus(if_c));

    localparam logic [2:0] PAT_A [0:8] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                                           3'b000, 3'b100, 3'b100, 3'b000};
    localparam logic [4:0] PAT_B [0:13] = '{5'b00001, 5'b00100, 5'b10000, 5'b00001,
                                            5'b00100, 5'b10000, 5'b00001, 5'b00100,
                                            5'b10000, 5'b00001, 5'b00010, 5'b00100,
                                            5'b01000, 5'b10000};
    localparam int IDX_B [0:13] = '{0, 2, 4, 0, 2, 4, 0, 2, 4, 0, 1, 2, 3, 4};
    localparam logic [3:0] PAT_C [0:5] = '{4'b0101, 4'b0101, 4'b0000,
                                           4'b1010, 4'b1010, 4'b0000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic [2:0] upd, input logic sw,
                            input logic busy, input int idx);
        check_eq({tag, "_upd"},  32'(if_a.UPDATE_SEQ), 32'(upd));
        check_eq({tag, "_swp"},  32'(if_a.SWEEP_DONE), 32'(sw));
        check_eq({tag, "_busy"}, 32'(if_a.BUSY),       32'(busy));
        check_eq({tag, "_idx"},  32'(if_a.ACTIVE_IDX), 32'(idx));
    endtask

    initial begin
        rst_n = 1'b0;
        if_a.EN = 1'b0; if_a.MODE = 1'b0; if_a.SKIP_MASK = '0; if_a.COLOR_MASK = '0;
        if_b.EN = 1'b0; if_b.MODE = 1'b0; if_b.SKIP_MASK = '0; if_b.COLOR_MASK = '0;
        if_c.EN = 1'b0; if_c.MODE = 1'b1; if_c.SKIP_MASK = '0; if_c.COLOR_MASK = 4'b0101;

        #12;
        expect_a("rst_a", 3'b000, 1'b0, 1'b0, 0);
        check_eq("rst_b_upd",  32'(if_b.UPDATE_SEQ), 32'd0);
        check_eq("rst_c_busy", 32'(if_c.BUSY), 32'd0);
        rst_n = 1'b1;

        // Defaults: legacy 3-p-bit pattern, two full sweeps plus slot 1 start.
        tick();
        check_eq("idle_a_busy", 32'(if_a.BUSY), 32'd0);
        if_a.EN = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            expect_a($sformatf("a%0d", k), PAT_A[k % 9], (k % 9) == 8, 1'b1, (k % 9) / 3);
        end

        // EN dropped in the first HOLD cycle of slot 1: slot completes, no sweep pulse.
        if_a.EN = 1'b0;
        tick(); expect_a("drop0", 3'b010, 1'b0, 1'b1, 1);
        tick(); expect_a("drop1", 3'b000, 1'b0, 1'b1, 1);
        tick(); expect_a("drop2", 3'b000, 1'b0, 1'b0, 0);
        tick(); expect_a("drop3", 3'b000, 1'b0, 1'b0, 0);
        if_a.EN = 1'b1;
        tick(); expect_a("reen", 3'b001, 1'b0, 1'b1, 0);

        // Asynchronous reset in the middle of a HOLD.
        #2 rst_n = 1'b0;
        #1 expect_a("arst", 3'b000, 1'b0, 1'b0, 0);
        #2 rst_n = 1'b1;
        tick(); expect_a("post_rst", 3'b001, 1'b0, 1'b1, 0);
        if_a.EN = 1'b0;

        // N=5, HOLD=1, GAP=0 with skips; mid-sweep mask change takes effect at wrap.
        if_b.SKIP_MASK = 5'b01010;
        if_b.EN = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            check_eq($sformatf("b%0d_upd", k), 32'(if_b.UPDATE_SEQ), 32'(PAT_B[k]));
            check_eq($sformatf("b%0d_swp", k), 32'(if_b.SWEEP_DONE), 32'(PAT_B[k] == 5'b10000));
            check_eq($sformatf("b%0d_idx", k), 32'(if_b.ACTIVE_IDX), 32'(IDX_B[k]));
            if (k == 6) if_b.SKIP_MASK = 5'b00000;
        end
        if_b.EN = 1'b0;

        // Two-colour mode, then COLOR all A (group B empty), then everything skipped.
        if_c.EN = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq($sformatf("c%0d_upd", k), 32'(if_c.UPDATE_SEQ), 32'(PAT_C[k % 6]));
            check_eq($sformatf("c%0d_swp", k), 32'(if_c.SWEEP_DONE), 32'((k % 6) == 5));
            check_eq($sformatf("c%0d_idx", k), 32'(if_c.ACTIVE_IDX), 32'((k % 6) / 3));
        end
        if_c.COLOR_MASK = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("ca%0d_upd", k), 32'(if_c.UPDATE_SEQ),
                     32'(((k % 3) == 2) ? 4'b0000 : 4'b1111));
            check_eq($sformatf("ca%0d_swp", k), 32'(if_c.SWEEP_DONE), 32'((k % 3) == 2));
            check_eq($sformatf("ca%0d_idx", k), 32'(if_c.ACTIVE_IDX), 32'd0);
        end
        if_c.SKIP_MASK = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("cs%0d_upd", k),  32'(if_c.UPDATE_SEQ), 32'd0);
            check_eq($sformatf("cs%0d_busy", k), 32'(if_c.BUSY), 32'd0);
            check_eq($sformatf("cs%0d_swp", k),  32'(if_c.SWEEP_DONE), 32'd0);
        end
        if_c.EN = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
